// File: rtl/hazard_pkg.sv
// hazard_pkg: shared forward-select codes and MDU sequencer state encoding
package hazard_pkg;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W = 2'b01;
  localparam logic [1:0] FWD_M = 2'b10;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} mdu_state_t;
endpackage

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multiply/divide unit occupancy FSM with countdown
// Ports: clock, reset (async, active-high), MduStartE (op issues from EX),
//        state (IDLE/BUSY/DONE), MduBusy (state not IDLE)
module mdu_sequencer
  import hazard_pkg::*;
#(
  parameter int MDU_CYCLES = 32,
  parameter int CNT_W = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       MduStartE,
  output mdu_state_t state,
  output logic       MduBusy
);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(MDU_CYCLES - 1);
  mdu_state_t state_n;
  logic [CNT_W-1:0] count, count_n;
  logic load;
  // A start seen while BUSY cannot happen (decode is held by mdustall), so it is ignored
  assign load = MduStartE && state != BUSY;
  always_comb begin
    state_n = load ? BUSY : state == BUSY ? (count == '0 ? DONE : BUSY) : IDLE;
    count_n = load ? LOAD : (state == BUSY && count != '0) ? count - CNT_W'(1) : count;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
    end
  assign MduBusy = state != IDLE;
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: stall/flush/forward resolution for the 5-stage MIPS pipeline
// Ports: clock, reset (async, active-high); register ids and write/load enables per
//        stage; BranchD, MduStartE, MduUseD, MemWaitM in.  Stall{F,D,E,M}, FlushE,
//        Forward{A,B}E (2b), Forward{A,B}D, MduBusy, Perf{Stall,Flush}Count out.
// Macro HAZARD_PERF_EN: enables saturating stall/flush performance counters;
//        when undefined the counter ports are tied to zero.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int MDU_CYCLES = 32,
  parameter int CNT_W = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  RsD,
  input  logic [4:0]  RtD,
  input  logic [4:0]  RsE,
  input  logic [4:0]  RtE,
  input  logic [4:0]  WriteRegE,
  input  logic [4:0]  WriteRegM,
  input  logic [4:0]  WriteRegW,
  input  logic        RegWriteE,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MemtoRegE,
  input  logic        MemtoRegM,
  input  logic        BranchD,
  input  logic        MduStartE,
  input  logic        MduUseD,
  input  logic        MemWaitM,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        ForwardAD,
  output logic        ForwardBD,
  output logic        MduBusy,
  output logic [31:0] PerfStallCount,
  output logic [31:0] PerfFlushCount
);
  mdu_state_t state;
  logic lwstall, brstall, mdustall, stall;
  mdu_sequencer #(.MDU_CYCLES(MDU_CYCLES), .CNT_W(CNT_W)) u_mdu (
    .clock(clock),
    .reset(reset),
    .MduStartE(MduStartE),
    .state(state),
    .MduBusy(MduBusy)
  );
  assign ForwardAE = (RsE != 5'd0 && RegWriteM && WriteRegM == RsE) ? FWD_M :
                     (RsE != 5'd0 && RegWriteW && WriteRegW == RsE) ? FWD_W : FWD_RF;
  assign ForwardBE = (RtE != 5'd0 && RegWriteM && WriteRegM == RtE) ? FWD_M :
                     (RtE != 5'd0 && RegWriteW && WriteRegW == RtE) ? FWD_W : FWD_RF;
  assign ForwardAD = RsD != 5'd0 && RegWriteM && WriteRegM == RsD;
  assign ForwardBD = RtD != 5'd0 && RegWriteM && WriteRegM == RtD;
  assign lwstall = MemtoRegE && (RtE == RsD || RtE == RtD);
  assign brstall = BranchD &&
                   ((RegWriteE && WriteRegE != 5'd0 && (WriteRegE == RsD || WriteRegE == RtD)) ||
                    (MemtoRegM && WriteRegM != 5'd0 && (WriteRegM == RsD || WriteRegM == RtD)));
  assign mdustall = MduUseD && state == BUSY;
  assign stall = lwstall | brstall | mdustall;
  // A memory wait freezes the whole front of the pipe; injecting a bubble then would lose an instruction
  assign StallF = MemWaitM | stall;
  assign StallD = MemWaitM | stall;
  assign StallE = MemWaitM;
  assign StallM = MemWaitM;
  assign FlushE = !MemWaitM && stall;
`ifdef HAZARD_PERF_EN
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      PerfStallCount <= '0;
      PerfFlushCount <= '0;
    end else begin
      if (StallF && !(&PerfStallCount)) PerfStallCount <= PerfStallCount + 32'd1;
      if (FlushE && !(&PerfFlushCount)) PerfFlushCount <= PerfFlushCount + 32'd1;
    end
`else
  assign PerfStallCount = '0;
  assign PerfFlushCount = '0;
`endif
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: scoreboard bench for hazard_controller (MDU_CYCLES=4)
module tb_hazard_controller;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD, MduStartE, MduUseD, MemWaitM;
  logic StallF, StallD, StallE, StallM, FlushE, ForwardAD, ForwardBD, MduBusy;
  logic [1:0] ForwardAE, ForwardBE;
  logic [31:0] PerfStallCount, PerfFlushCount;
  logic [13:0] obs;
  typedef struct {string name; logic [13:0] v;} exp_t;
  typedef struct {string name; logic [63:0] v;} pexp_t;
  exp_t q[$];
  exp_t e;
  pexp_t pq[$];
  pexp_t pe;
  int checks = 0;
  int errors = 0;
  localparam logic [3:0] S_NO = 4'b0000, S_HZ = 4'b1100, S_MEM = 4'b1111;

  hazard_controller #(.MDU_CYCLES(4), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
    .MduStartE(MduStartE), .MduUseD(MduUseD), .MemWaitM(MemWaitM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .MduBusy(MduBusy), .PerfStallCount(PerfStallCount), .PerfFlushCount(PerfFlushCount)
  );

  always #5 clock = ~clock;
  assign obs = {StallF, StallD, StallE, StallM, FlushE, ForwardAE, ForwardBE, ForwardAD, ForwardBD, MduBusy};

  function automatic logic [13:0] mk(input logic [3:0] st, input logic fl, input logic [1:0] fa, input logic [1:0] fb,
                                     input logic ad, input logic bd, input logic bsy);
    return {st, fl, fa, fb, ad, bd, bsy};
  endfunction

  task automatic clear();
    {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
    {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD, MduStartE, MduUseD, MemWaitM} = '0;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    clear();
    q.push_back('{"reset_outputs", mk(S_NO, 0, 2'b00, 2'b00, 0, 0, 0)});
    pq.push_back('{"reset_perf", 64'd0});
    @(negedge clock); e = q.pop_front(); checks++; if (obs !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.v); end
    pe = pq.pop_front(); checks++; if ({PerfStallCount, PerfFlushCount} !== pe.v) begin errors++; $display("FAIL %s got %h want %h", pe.name, {PerfStallCount, PerfFlushCount}, pe.v); end
    cyc(); reset = 1'b0;
  endtask

  task automatic test_forward();
    cyc(); RegWriteM = 1; WriteRegM = 5; RsE = 5; RtE = 5; RegWriteW = 1; WriteRegW = 5;
    q.push_back('{"fwd_m_priority", mk(S_NO, 0, 2'b10, 2'b10, 0, 0, 0)});
    @(negedge clock); e = q.pop_front(); checks++; if (obs !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.v); end
    cyc(); RegWriteM = 0;
    q.push_back('{"fwd_w", mk(S_NO, 0, 2'b01, 2'b01, 0, 0, 0)});
    @(negedge clock); e = q.pop_front(); checks++; if (obs !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.v); end
    cyc(); RsE = 0;
    q.push_back('{"fwd_rs_zero", mk(S_NO, 0, 2'b00, 2'b01, 0, 0, 0)});
    @(negedge clock); e = q.pop_front(); checks++; if (obs !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.v); end
    cyc(); RegWriteM = 1; WriteRegM = 0; WriteRegW = 0; RtE = 0;
    q.push_back('{"fwd_reg0", mk(S_NO, 0, 2'b00, 2'b00, 0, 0, 0)});
    @(negedge clock); e = q.pop_front(); checks++; if (obs !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.v); end
    cyc(); RsE = 4; RtE = 9; WriteRegM = 9; WriteRegW = 9;
    q.push_back('{"fwd_b_only", mk(S_NO, 0, 2'b00, 2'b10, 0, 0, 0)});
    @(negedge clock); e = q.pop_front(); checks++; if (obs !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.v); end
    clear();
  endtask

  task automatic test_load_use();
    cyc(); MemtoRegE = 1; RtE = 8; RsD = 8;
    q.push_back('{"lw_rs", mk(S_HZ, 1, 2'b00, 2'b00, 0, 0, 0)});
    @(negedge clock); e = q.pop_front(); checks++; if (obs !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.v); end
    cyc(); MemtoRegE = 0;
    q.push_back('{"lw_released", mk(S_NO, 0, 2'b00, 2'b00, 0, 0, 0)});
    @(negedge clock); e = q.pop_front(); checks++; if (obs !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.v); end
    cyc(); MemtoRegE = 1; RsD = 2; RtD = 8;
    q.push_back('{"lw_rt", mk(S_HZ, 1, 2'b00, 2'b00, 0, 0, 0)});
    @(negedge clock); e = q.pop_front(); checks++; if (obs !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.v); end
    cyc(); RsD = 7; RtD = 6;
    q.push_back('{"lw_no_match", mk(S_NO, 0, 2'b00, 2'b00, 0, 0, 0)});
    @(negedge clock); e = q.pop_front(); checks++; if (obs !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.v); end
    clear();
  endtask

  task automatic test_branch();
    cyc(); BranchD = 1; RegWriteE = 1; WriteRegE = 3; RsD = 3;
    q.push_back('{"br_alu_in_e", mk(S_HZ, 1, 2'b00, 2'b00, 0, 0, 0)});
    @(negedge clock); e = q.pop_front(); checks++; if (obs !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.v); end
    cyc(); RegWriteE = 0; WriteRegE = 0; RegWriteM = 1; WriteRegM = 3;
    q.push_back('{"br_fwd_m", mk(S_NO, 0, 2'b00, 2'b00, 1, 0, 0)});
    @(negedge clock); e = q.pop_front(); checks++; if (obs !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.v); end
    cyc(); MemtoRegM = 1;
    q.push_back('{"br_load_in_m", mk(S_HZ, 1, 2'b00, 2'b00, 1, 0, 0)});
    @(negedge clock); e = q.pop_front(); checks++; if (obs !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.v); end
    cyc(); MemtoRegM = 0; RsD = 0; RtD = 3;
    q.push_back('{"br_fwd_bd", mk(S_NO, 0, 2'b00, 2'b00, 0, 1, 0)});
    @(negedge clock); e = q.pop_front(); checks++; if (obs !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.v); end
    cyc(); RegWriteM = 0; WriteRegM = 0; MemtoRegM = 1; RegWriteE = 1; WriteRegE = 0; RtD = 0;
    q.push_back('{"br_reg0", mk(S_NO, 0, 2'b00, 2'b00, 0, 0, 0)});
    @(negedge clock); e = q.pop_front(); checks++; if (obs !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.v); end
    cyc(); MemtoRegM = 0; MemtoRegE = 1; RtE = 4; RsD = 4; WriteRegE = 4;
    q.push_back('{"lw_and_br", mk(S_HZ, 1, 2'b00, 2'b00, 0, 0, 0)});
    @(negedge clock); e = q.pop_front(); checks++; if (obs !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.v); end
    clear();
  endtask

  task automatic test_mdu();
    cyc(); MduStartE = 1; MduUseD = 1;
    q.push_back('{"mdu_issue_idle", mk(S_NO, 0, 2'b00, 2'b00, 0, 0, 0)});
    @(negedge clock); e = q.pop_front(); checks++; if (obs !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.v); end
    for (int i = 0; i < 4; i++) begin
      cyc(); MduStartE = 0;
      q.push_back('{$sformatf("mdu_busy_%0d", i), mk(S_HZ, 1, 2'b00, 2'b00, 0, 0, 1)});
      @(negedge clock); e = q.pop_front(); checks++; if (obs !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.v); end
    end
    cyc();
    q.push_back('{"mdu_done", mk(S_NO, 0, 2'b00, 2'b00, 0, 0, 1)});
    @(negedge clock); e = q.pop_front(); checks++; if (obs !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.v); end
    cyc();
    q.push_back('{"mdu_idle", mk(S_NO, 0, 2'b00, 2'b00, 0, 0, 0)});
    @(negedge clock); e = q.pop_front(); checks++; if (obs !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.v); end
    clear();
  endtask

  task automatic test_back_to_back();
    cyc(); MduStartE = 1;
    for (int i = 0; i < 4; i++) begin
      cyc(); MduStartE = 0;
    end
    cyc(); MduStartE = 1;
    q.push_back('{"b2b_done_restart", mk(S_NO, 0, 2'b00, 2'b00, 0, 0, 1)});
    @(negedge clock); e = q.pop_front(); checks++; if (obs !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.v); end
    for (int i = 0; i < 4; i++) begin
      cyc(); MduStartE = 0; MduUseD = 1;
      q.push_back('{$sformatf("b2b_busy_%0d", i), mk(S_HZ, 1, 2'b00, 2'b00, 0, 0, 1)});
      @(negedge clock); e = q.pop_front(); checks++; if (obs !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.v); end
    end
    cyc();
    q.push_back('{"b2b_done", mk(S_NO, 0, 2'b00, 2'b00, 0, 0, 1)});
    @(negedge clock); e = q.pop_front(); checks++; if (obs !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.v); end
    cyc();
    q.push_back('{"b2b_idle", mk(S_NO, 0, 2'b00, 2'b00, 0, 0, 0)});
    @(negedge clock); e = q.pop_front(); checks++; if (obs !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.v); end
    clear();
  endtask

  task automatic test_mem_wait();
    cyc(); MemWaitM = 1; MemtoRegE = 1; RtE = 8; RsD = 8;
    q.push_back('{"mem_over_lw", mk(S_MEM, 0, 2'b00, 2'b00, 0, 0, 0)});
    @(negedge clock); e = q.pop_front(); checks++; if (obs !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.v); end
    cyc(); MemtoRegE = 0;
    q.push_back('{"mem_alone", mk(S_MEM, 0, 2'b00, 2'b00, 0, 0, 0)});
    @(negedge clock); e = q.pop_front(); checks++; if (obs !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.v); end
    clear();
    cyc(); MduStartE = 1;
    for (int i = 0; i < 4; i++) begin
      cyc(); MduStartE = 0; MemWaitM = 1; MduUseD = 1;
      q.push_back('{$sformatf("mem_mdu_busy_%0d", i), mk(S_MEM, 0, 2'b00, 2'b00, 0, 0, 1)});
      @(negedge clock); e = q.pop_front(); checks++; if (obs !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.v); end
    end
    cyc(); MemWaitM = 0;
    q.push_back('{"mem_mdu_done", mk(S_NO, 0, 2'b00, 2'b00, 0, 0, 1)});
    @(negedge clock); e = q.pop_front(); checks++; if (obs !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.v); end
    clear();
  endtask

  task automatic test_async_reset();
    cyc(); MduStartE = 1;
    cyc(); MduStartE = 0; MduUseD = 1;
    q.push_back('{"ar_busy", mk(S_HZ, 1, 2'b00, 2'b00, 0, 0, 1)});
    @(negedge clock); e = q.pop_front(); checks++; if (obs !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.v); end
    cyc(); #1 reset = 1'b1;
    q.push_back('{"ar_immediate", mk(S_NO, 0, 2'b00, 2'b00, 0, 0, 0)});
    #1 e = q.pop_front(); checks++; if (obs !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.v); end
    cyc(); reset = 1'b0;
    q.push_back('{"ar_released", mk(S_NO, 0, 2'b00, 2'b00, 0, 0, 0)});
    @(negedge clock); e = q.pop_front(); checks++; if (obs !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.v); end
    clear();
  endtask

  task automatic test_perf();
    cyc(); reset = 1'b1;
    cyc(); reset = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      MemtoRegE = 1; RtE = 8; RsD = 8;
      cyc();
    end
    clear();
    MemWaitM = 1;
    cyc();
    cyc();
    clear();
`ifdef HAZARD_PERF_EN
    pq.push_back('{"perf_counts", {32'd5, 32'd3}});
`else
    pq.push_back('{"perf_counts", 64'd0});
`endif
    @(negedge clock); pe = pq.pop_front(); checks++; if ({PerfStallCount, PerfFlushCount} !== pe.v) begin errors++; $display("FAIL %s got %h want %h", pe.name, {PerfStallCount, PerfFlushCount}, pe.v); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_mdu();
    test_back_to_back();
    test_mem_wait();
    test_async_reset();
    test_perf();
    if (q.size() != 0 || pq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d want 0", q.size() + pq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Hazard-resolution and stall/flush sequencer for the 5-stage MIPS pipeline.
- Replaces the tied-off stall, flush and forward nets at the top level.
- Drives StallF/StallD/FlushE and forward selects for EX (ForwardAE/BE) and the branch compare in decode (ForwardAD/BD).
- Sequences multi-cycle multiply/divide (MDU) occupancy and data-memory wait stalls.

Parameters:
- MDU_CYCLES, 32, cycles an MDU op occupies the unit after issue (≥2).
- CNT_W, 6, width of the MDU countdown counter; must hold MDU_CYCLES.

Ports:
- clock  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high reset
- RsD, RtD  in  5 each  decode source register ids
- RsE, RtE  in  5 each  execute source register ids
- WriteRegE, WriteRegM, WriteRegW  in  5 each  destination ids per stage
- RegWriteE, RegWriteM, RegWriteW  in  1 each  register-write enables per stage
- MemtoRegE, MemtoRegM  in  1 each  load in stage
- BranchD  in  1  branch/jump-register in decode needing register compare
- MduStartE  in  1  MDU op issuing from EX this cycle
- MduUseD  in  1  decode instruction reads HI/LO or issues another MDU op
- MemWaitM  in  1  data memory not ready; M-stage access incomplete
- StallF, StallD, StallE, StallM  out  1 each  hold pipeline registers
- FlushE  out  1  clear ID/EX register (bubble)
- ForwardAE, ForwardBE  out  2 each  EX operand select
- ForwardAD, ForwardBD  out  1 each  decode compare forwards ALUOutM
- MduBusy  out  1  MDU FSM not idle
- PerfStallCount, PerfFlushCount  out  32 each  performance counters

Behaviour:
- Forward encoding: 2'b00 register file, 2'b01 ResultW, 2'b10 ALUOutM.
- ForwardAE = 10 if RsE≠0 && RegWriteM && WriteRegM==RsE; else 01 if RsE≠0 && RegWriteW && WriteRegW==RsE; else 00. M has priority over W. ForwardBE is identical with RtE.
- ForwardAD = RsD≠0 && RegWriteM && WriteRegM==RsD; ForwardBD likewise with RtD.
- lwstall = MemtoRegE && (RtE==RsD || RtE==RtD).
- brstall = BranchD && ((RegWriteE && WriteRegE≠0 && (WriteRegE==RsD || WriteRegE==RtD)) || (MemtoRegM && WriteRegM≠0 && (WriteRegM==RsD || WriteRegM==RtD))).
- Register 0 is never a hazard source.
- MDU FSM states: IDLE, BUSY, DONE.
  - IDLE -> BUSY on MduStartE; counter loads MDU_CYCLES-1.
  - BUSY decrements each cycle; BUSY -> DONE when counter==0.
  - DONE -> IDLE after one cycle; MduStartE in DONE restarts BUSY directly.
  - MduStartE while BUSY is ignored; it cannot occur because it is stalled by mdustall.
- MduBusy = state≠IDLE, registered.
- mdustall = MduUseD && state==BUSY.
- memstall = MemWaitM.
- When memstall: StallF=StallD=StallE=StallM=1, FlushE=0. memstall dominates all other conditions. The MDU counter keeps counting during memstall.
- Otherwise: StallF=StallD=FlushE = lwstall|brstall|mdustall, and StallE=StallM=0.
- Simultaneous lwstall+brstall costs one stall cycle per cycle asserted; no double flush.
- All stall/flush/forward outputs are combinational from inputs and registered state. Zero-cycle latency.
- Reset (asynchronous, any time, including mid-BUSY): state=IDLE, counter=0, MduBusy=0, perf counters=0. Stall/flush outputs follow inputs with the FSM in IDLE.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: PerfStallCount increments each cycle StallF=1; PerfFlushCount increments each cycle FlushE=1. Both saturate at 32'hFFFFFFFF.
- Undefined: no counter flops; both ports drive 32'h0.

Decomposition:
- Package hazard_pkg holds:
  - forward-select constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10
  - MDU state typedef/encoding: IDLE=2'd0, BUSY=2'd1, DONE=2'd2
- One sub-module, mdu_sequencer: FSM plus countdown. Inputs clock, reset, MduStartE; outputs state, MduBusy.
- Forwarding and stall logic stays in hazard_controller.

Test Plan:
- RAW forward: RegWriteM=1, WriteRegM=5, RsE=5, plus RegWriteW=1, WriteRegW=5 -> ForwardAE=10. Drop the M write -> ForwardAE=01. Set RsE=0 -> ForwardAE=00.
- Load-use: MemtoRegE=1, RtE=8, RsD=8 -> StallF=StallD=FlushE=1 for exactly one cycle; next cycle with MemtoRegE=0 -> all 0.
- Branch: BranchD=1, RegWriteE=1, WriteRegE=3, RsD=3 -> stall asserted. Next cycle the value is in M with MemtoRegM=0 -> no stall, ForwardAD=1.
- MDU: MduStartE pulse with MDU_CYCLES=4 -> MduBusy high 5 cycles (BUSY×4, DONE×1). MduUseD=1 during BUSY -> StallD=1; in DONE -> StallD=0.
- Mem wait dominance: MemWaitM=1 together with lwstall -> all four stalls=1, FlushE=0. Async reset asserted mid-BUSY -> MduBusy=0 immediately, before the next clock edge.
- With HAZARD_PERF_EN: 3 load-use stalls plus 2 memwait cycles -> PerfStallCount=5, PerfFlushCount=3.
